uart_rx: RTL and testbench

Serial receiver for the UART: recovers SIZE-bit frames from the asynchronous `rx` line, 8N1 by default (optionally 8E1/8O1), LSB first. It sits behind the `rx` pin of the UART top and drives `data_out`/`rx_done`. The transmitter consumes `tx_en`/`data_in` on the other side of the same link. The block oversamples with a fixed clock count per bit and samples each bit at mid-bit.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side output bundle of the UART: recovered frame plus status pulses.
interface uart_rx_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] data_out;
  logic            rx_done;
  logic            rx_busy;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output data_out,
    output rx_done,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport slave (
    input data_out,
    input rx_done,
    input rx_busy,
    input frame_err,
    input parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART serial receiver, mid-bit sampling with a fixed clock count per bit, LSB first.
// Define UART_RX_PARITY_EN to add a parity bit between the data and the stop bit.
module uart_rx #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_n;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [IDXW-1:0] idx, idx_n;
  logic [SIZE-1:0] shreg, shreg_n;
  logic [SIZE-1:0] data_q, data_n;
  logic            done_q, done_n;
  logic            ferr_q, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic            mism_q, mism_n;
  logic            perr_q, perr_n;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mism_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], rx};
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      data_q <= data_n;
      done_q <= done_n;
      ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
      mism_q <= mism_n;
      perr_q <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    mism_n  = mism_q;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      // Start bit must still be low at its midpoint, otherwise it was a glitch.
      START: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BIT_LAST) begin
          shreg_n[idx] = rx_s;
          cnt_n        = '0;
          idx_n        = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BIT_LAST) begin
          mism_n  = rx_s ^ (^shreg) ^ PARITY_ODD;
          cnt_n   = '0;
          state_n = STOP;
        end
      end
`endif
      // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
      STOP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_n = shreg;
            done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_n = mism_q;
`endif
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.rx_done   = done_q;
  assign bus.rx_busy   = (state != IDLE);
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  // Parity sense has no effect when there is no parity bit.
  assign bus.parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit and the expected
// pulses (with their exact cycle) are queued, then matched when the receiver reports.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int N = 2 + H + (8 + 1 + PBITS) * CPB;

  typedef struct {
    logic       isGood;
    logic [7:0] data;
    logic       perr;
    int         cycle;
  } exp_t;

  logic clk;
  logic rst;
  logic rx;
  int   cycleCount;
  int   checkCount;
  int   passCount;
  logic [7:0] lastGood;
  exp_t expQ[$];
  exp_t monExp;

  uart_rx_if #(.SIZE(8)) bus ();

  uart_rx #(
    .SIZE(8),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCount = 0;
  always @(posedge clk) cycleCount++;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  // Drives one frame starting at a negedge and queues what the receiver should report.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badPar);
    exp_t e;
    logic parBit;
    parBit   = (^data) ^ PAR_ODD ^ badPar;
    e.cycle  = cycleCount + 1 + N;
    e.isGood = stopBit;
    e.data   = stopBit ? data : lastGood;
    e.perr   = stopBit & badPar & (PBITS == 1);
    if (stopBit) lastGood = data;
    expQ.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    if (PBITS == 1) begin
      rx = parBit;
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && (bus.rx_done || bus.frame_err || bus.parity_err)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, bus.rx_done, bus.frame_err, bus.parity_err}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rx_done", {31'd0, bus.rx_done}, {31'd0, monExp.isGood});
        checkOutput("frame_err", {31'd0, bus.frame_err}, {31'd0, !monExp.isGood});
        checkOutput("parity_err", {31'd0, bus.parity_err}, {31'd0, monExp.perr});
        checkOutput("data_out", {24'd0, bus.data_out}, {24'd0, monExp.data});
        checkOutput("pulse_cycle", cycleCount, monExp.cycle);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    lastGood   = 8'h00;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    checkOutput("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
    checkOutput("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] glitch rejection");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    checkOutput("glitch_busy_high", {31'd0, bus.rx_busy}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] stop-bit error");
    applyStimulus(8'h5A, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("ferr_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    checkOutput("ferr_data_held", {24'd0, bus.data_out}, 32'h3C);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);

    if (PBITS == 1) begin
      $display("[TB] parity");
      applyStimulus(8'h07, 1'b1, 1'b0);
      applyStimulus(8'h07, 1'b1, 1'b1);
      repeat (2 * CPB) @(negedge clk);
    end

    $display("[TB] break");
    begin
      exp_t e;
      int edge0;
      edge0    = cycleCount + 1;
      e.isGood = 1'b0;
      e.data   = lastGood;
      e.perr   = 1'b0;
      e.cycle  = edge0 + N;
      expQ.push_back(e);
      e.cycle  = edge0 + 2 * N - 1;
      expQ.push_back(e);
      rx = 1'b0;
      repeat (2 * N + 2) @(negedge clk);
      rx = 1'b1;
    end
    repeat (3 * CPB) @(negedge clk);
    checkOutput("break_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    applyStimulus(8'h96, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] reset mid-frame");
    begin
      logic [7:0] partial;
      partial = 8'hC3;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rx = partial[i];
        repeat (CPB) @(negedge clk);
      end
    end
    checkOutput("midframe_busy", {31'd0, bus.rx_busy}, 32'd1);
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    checkOutput("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
    checkOutput("midrst_rx_done", {31'd0, bus.rx_done}, 32'd0);
    checkOutput("midrst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    checkOutput("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("midrst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    lastGood = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (CPB) @(negedge clk);
    applyStimulus(8'h12, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);

    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
